// File: rtl/parking_pkg.sv
// Shared types and default sizing for the parking-lot barrier gate controller.
package parking_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GRANT_IN  = 3'd1,
        GRANT_OUT = 3'd2,
        OPEN      = 3'd3,
        CLOSE     = 3'd4
    } gate_state_t;

    localparam int DEF_CAPACITY = 3;
    localparam int DEF_OPEN_CYC = 4;
    localparam int DEF_CNT_W    = 4;
    // Wide enough for OPEN_CYC up to 15.
    localparam int TMR_W        = 4;

endpackage

// File: rtl/gate_controller_if.sv
// Entry/exit sensor handshake bundle for the gate controller.
interface gate_controller_if;
    // Handshake: a sensor raises its req as a level and holds it until the
    // matching one-cycle gnt; it drops req the cycle after gnt. A req seen high
    // while the controller is idle is a new request. Ineligible reqs stay pending.
    logic enter_req;
    logic exit_req;
    logic enter_gnt;
    logic exit_gnt;

    modport master (output enter_req, output exit_req, input enter_gnt, input exit_gnt);
    modport slave  (input enter_req, input exit_req, output enter_gnt, output exit_gnt);
endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin picker; a = entry, b = exit. Exit counts as last served
// out of reset so the entry side wins the first tie.
module rr_arb2 (
    input  logic clk,
    input  logic reset,
    input  logic req_a,
    input  logic req_b,
    input  logic update,
    output logic gnt_a,
    output logic gnt_b
);
    logic last_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_b <= 1'b1;
        end else if (update) begin
            last_b <= gnt_b;
        end
    end

    assign gnt_a = req_a & (~req_b | last_b);
    assign gnt_b = req_b & (~req_a | ~last_b);
endmodule

// File: rtl/gate_controller.sv
// Shared barrier gate sequencer with occupancy tracking. Define GATE_STATS_EN
// to build the hourly entry counter and its log write port.
module gate_controller
    import parking_pkg::*;
#(
    parameter int CAPACITY = DEF_CAPACITY,
    parameter int OPEN_CYC = DEF_OPEN_CYC,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    gate_controller_if.slave   bus,
    input  logic               increaseTime,
    input  logic [2:0]         hours,
    input  logic               endDay,
    output logic               gate_open,
    output logic [CNT_W-1:0]   occupancy,
    output logic               full,
    output logic               empty,
    output logic               log_we,
    output logic [2:0]         log_addr,
    output logic [CNT_W-1:0]   log_data,
    output gate_state_t        state
);
    localparam logic [TMR_W-1:0] OPEN_LOAD = TMR_W'(OPEN_CYC - 2);

    logic [TMR_W-1:0] tmr;
    logic             idle;
    logic             pick_in;
    logic             pick_out;

    assign full  = (occupancy == CNT_W'(CAPACITY));
    assign empty = (occupancy == '0);
    assign idle  = (state == IDLE);

    rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req_a  (idle & bus.enter_req & ~full  & ~endDay),
        .req_b  (idle & bus.exit_req  & ~empty & ~endDay),
        .update (pick_in | pick_out),
        .gnt_a  (pick_in),
        .gnt_b  (pick_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            bus.enter_gnt <= 1'b0;
            bus.exit_gnt  <= 1'b0;
            gate_open     <= 1'b0;
            occupancy     <= '0;
            tmr           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_in) begin
                        state         <= GRANT_IN;
                        bus.enter_gnt <= 1'b1;
                        gate_open     <= 1'b1;
                        occupancy     <= occupancy + CNT_W'(1);
                    end else if (pick_out) begin
                        state         <= GRANT_OUT;
                        bus.exit_gnt  <= 1'b1;
                        gate_open     <= 1'b1;
                        occupancy     <= occupancy - CNT_W'(1);
                    end
                end
                GRANT_IN, GRANT_OUT: begin
                    bus.enter_gnt <= 1'b0;
                    bus.exit_gnt  <= 1'b0;
                    tmr           <= OPEN_LOAD;
                    state         <= OPEN;
                end
                // The grant cycle already counted as one open cycle.
                OPEN: begin
                    if (tmr == '0) begin
                        gate_open <= 1'b0;
                        state     <= CLOSE;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                CLOSE: state <= IDLE;
                default: begin
                    state         <= IDLE;
                    bus.enter_gnt <= 1'b0;
                    bus.exit_gnt  <= 1'b0;
                    gate_open     <= 1'b0;
                end
            endcase
        end
    end

`ifdef GATE_STATS_EN
    logic [CNT_W-1:0] hour_cnt;

    // An entry granted on the pulse edge belongs to the new hour.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hour_cnt <= '0;
            log_we   <= 1'b0;
            log_addr <= '0;
            log_data <= '0;
        end else begin
            log_we <= increaseTime;
            if (increaseTime) begin
                log_addr <= hours;
                log_data <= hour_cnt;
                hour_cnt <= pick_in ? CNT_W'(1) : '0;
            end else if (pick_in && (hour_cnt != '1)) begin
                hour_cnt <= hour_cnt + CNT_W'(1);
            end
        end
    end
`else
    logic unused_stats;
    assign unused_stats = ^{increaseTime, hours};
    assign log_we   = 1'b0;
    assign log_addr = '0;
    assign log_data = '0;
`endif
endmodule

// File: tb/tb_gate_controller.sv
// Directed bench for gate_controller with a time-based behavioural model.
module tb_gate_controller;
  import parking_pkg::*;

  localparam int CAPACITY = 3;
  localparam int OPEN_CYC = 4;
  localparam int CNT_W    = 4;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic             increaseTime = 1'b0;
  logic [2:0]       hours = 3'd0;
  logic             endDay = 1'b0;
  logic             gate_open;
  logic [CNT_W-1:0] occupancy;
  logic             full;
  logic             empty;
  logic             log_we;
  logic [2:0]       log_addr;
  logic [CNT_W-1:0] log_data;
  gate_state_t      dbg_state;

  gate_controller_if bus ();

  gate_controller #(.CAPACITY(CAPACITY), .OPEN_CYC(OPEN_CYC), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .increaseTime (increaseTime),
    .hours        (hours),
    .endDay       (endDay),
    .gate_open    (gate_open),
    .occupancy    (occupancy),
    .full         (full),
    .empty        (empty),
    .log_we       (log_we),
    .log_addr     (log_addr),
    .log_data     (log_data),
    .state        (dbg_state)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each grant is an edge number; gate is open for OPEN_CYC cycles from it,
  // and the next grant may come no earlier than OPEN_CYC+2 edges later.
  int e_no = 0;
  int g_last = -100;
  int occ_m = 0;
  int hcnt_m = 0;
  bit last_exit_m = 1'b1;
  bit side_in_m = 1'b0;
  bit ei, eo, take_in, took_in;
  bit exp_log_we = 1'b0;
  int exp_log_addr = 0;
  int exp_log_data = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      e_no = 0; g_last = -100; occ_m = 0; hcnt_m = 0;
      last_exit_m = 1'b1; side_in_m = 1'b0;
      exp_log_we = 1'b0; exp_log_addr = 0; exp_log_data = 0;
    end else begin
      e_no++;
      took_in = 1'b0;
      if (e_no >= g_last + OPEN_CYC + 2) begin
        ei = bus.enter_req && (occ_m < CAPACITY) && !endDay;
        eo = bus.exit_req && (occ_m > 0) && !endDay;
        if (ei || eo) begin
          take_in = ei && (!eo || last_exit_m);
          g_last = e_no;
          side_in_m = take_in;
          last_exit_m = !take_in;
          occ_m += take_in ? 1 : -1;
          took_in = take_in;
        end
      end
`ifdef GATE_STATS_EN
      if (increaseTime) begin
        exp_log_we = 1'b1;
        exp_log_addr = hours;
        exp_log_data = hcnt_m;
        hcnt_m = took_in ? 1 : 0;
      end else begin
        exp_log_we = 1'b0;
        if (took_in && hcnt_m < (1 << CNT_W) - 1) hcnt_m++;
      end
`endif
    end
  end

  // Scoreboard compare on every falling edge.
  always @(negedge clk) begin
    check("enter_gnt", bus.enter_gnt, (e_no == g_last) && side_in_m);
    check("exit_gnt", bus.exit_gnt, (e_no == g_last) && !side_in_m);
    check("gate_open", gate_open, (e_no - g_last >= 0) && (e_no - g_last < OPEN_CYC));
    check("occupancy", occupancy, occ_m);
    check("full", full, occ_m == CAPACITY);
    check("empty", empty, occ_m == 0);
    check("log_we", log_we, exp_log_we);
`ifdef GATE_STATS_EN
    if (exp_log_we) begin
      check("log_addr", log_addr, exp_log_addr);
      check("log_data", log_data, exp_log_data);
    end
`else
    check("log_addr", log_addr, 0);
    check("log_data", log_data, 0);
`endif
  end

  // driver: sensors hold req while cars wait, dropping it the cycle after gnt
  int want_in = 0;
  int want_out = 0;
  int tick_no = 0;
  int in_gnts = 0;
  int out_gnts = 0;
  int gate_ticks = 0;
  logic [1:0] exp_q[$];
  logic [1:0] obs_q[$];
  int obs_tick_q[$];

  task automatic tick();
    @(negedge clk);
    tick_no++;
    if (gate_open) gate_ticks++;
    if (bus.enter_gnt) begin
      in_gnts++; obs_q.push_back(2'd1); obs_tick_q.push_back(tick_no);
      if (want_in > 0) want_in--;
      bus.enter_req = 1'b0;
    end else begin
      bus.enter_req = (want_in > 0);
    end
    if (bus.exit_gnt) begin
      out_gnts++; obs_q.push_back(2'd2); obs_tick_q.push_back(tick_no);
      if (want_out > 0) want_out--;
      bus.exit_req = 1'b0;
    end else begin
      bus.exit_req = (want_out > 0);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic request(input int n_in, input int n_out);
    want_in += n_in;
    want_out += n_out;
    bus.enter_req = (want_in > 0);
    bus.exit_req = (want_out > 0);
  endtask

  task automatic wait_gnt(input bit side_in, input int budget, output int waited);
    int g0;
    g0 = side_in ? in_gnts : out_gnts;
    waited = budget + 1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if ((side_in ? in_gnts : out_gnts) != g0) begin
        waited = i;
        break;
      end
    end
  endtask

  task automatic pulse_hour(input logic [2:0] h);
    hours = h;
    increaseTime = 1'b1;
    tick();
    increaseTime = 1'b0;
  endtask

  int w, g0, o0;

  initial begin
    bus.enter_req = 1'b0;
    bus.exit_req = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_state", dbg_state, IDLE);
    check("rst_gate_open", gate_open, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_log_we", log_we, 0);
    reset = 1'b0;

    // single entry
    gate_ticks = 0;
    request(1, 0);
    wait_gnt(1'b1, 10, w);
    check("t1_gnt_latency", w, 1);
    run(10);
    check("t1_gate_cycles", gate_ticks, 4);
    check("t1_occupancy", occupancy, 1);
    check("t1_empty", empty, 0);

    // fill, then blocked entry until an exit completes
    request(2, 0);
    run(20);
    check("t2_occupancy", occupancy, 3);
    check("t2_full", full, 1);
    g0 = in_gnts;
    request(1, 0);
    run(20);
    check("t2_no_gnt_full", in_gnts - g0, 0);
    o0 = out_gnts;
    obs_tick_q.delete();
    request(0, 1);
    run(20);
    check("t2_exit_gnts", out_gnts - o0, 1);
    check("t2_entry_after_exit", in_gnts - g0, 1);
    check("t2_gnt_spacing", obs_tick_q.size() == 2 ? obs_tick_q[1] - obs_tick_q[0] : 0, 6);
    check("t2_occupancy_end", occupancy, 3);

    // drain to 1, then both sides held: entry, exit, entry
    request(0, 2);
    run(20);
    check("t3_occupancy_start", occupancy, 1);
    obs_q.delete();
    obs_tick_q.delete();
    exp_q = '{2'd1, 2'd2, 2'd1};
    request(2, 1);
    run(30);
    check("t3_gnt_count", obs_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < obs_q.size()) check("t3_gnt_order", obs_q[i], exp_q[i]);
    end
    if (obs_tick_q.size() == 3) begin
      check("t3_spacing_a", obs_tick_q[1] - obs_tick_q[0], 6);
      check("t3_spacing_b", obs_tick_q[2] - obs_tick_q[1], 6);
    end
    check("t3_occupancy_end", occupancy, 2);

    // exit with empty lot is ignored
    request(0, 2);
    run(20);
    check("t4_empty", empty, 1);
    gate_ticks = 0;
    o0 = out_gnts;
    request(0, 1);
    run(10);
    check("t4_no_exit_gnt", out_gnts - o0, 0);
    check("t4_gate_closed", gate_ticks, 0);
    want_out = 0;
    bus.exit_req = 1'b0;
    run(2);

`ifdef GATE_STATS_EN
    pulse_hour(3'd2);
    check("t5_clear_log_we", log_we, 1);
    request(2, 0);
    run(20);
    pulse_hour(3'd3);
    check("t5_log_we", log_we, 1);
    check("t5_log_addr", log_addr, 3);
    check("t5_log_data", log_data, 2);
    tick();
    check("t5_log_we_drop", log_we, 0);
    request(1, 0);
    pulse_hour(3'd4);
    check("t5_gnt_on_pulse", bus.enter_gnt, 1);
    check("t5_log_data_b", log_data, 0);
    run(20);
    pulse_hour(3'd5);
    check("t5_next_hour_cnt", log_data, 1);
    request(0, 3);
    run(30);
    check("t5_drained", occupancy, 0);
`endif

    // endDay during OPEN, then reset mid-OPEN
    gate_ticks = 0;
    request(1, 0);
    wait_gnt(1'b1, 10, w);
    check("t6_gnt_latency", w, 1);
    tick();
    endDay = 1'b1;
    g0 = in_gnts;
    request(1, 0);
    run(15);
    check("t6_gate_completes", gate_ticks, 4);
    check("t6_frozen", in_gnts - g0, 0);
    endDay = 1'b0;
    wait_gnt(1'b1, 10, w);
    check("t6_gnt_after_endday", w, 1);
    check("t6_occupancy", occupancy, 2);
    run(2);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_gate_open", gate_open, 0);
    check("t6_rst_occupancy", occupancy, 0);
    check("t6_rst_empty", empty, 1);
    want_in = 0; want_out = 0;
    bus.enter_req = 1'b0; bus.exit_req = 1'b0;
    run(2);
    reset = 1'b0;
    run(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/gate_controller.md
# gate_controller

Sequences the single shared barrier gate of the parking lot between the entry and exit sensors. Arbitrates the two requesters round-robin, times the gate-open window, and tracks lot occupancy with full/empty flags. Records per-hour entry counts for the hour-tracking FSM's day cycle. Sits between the sensor front end and the hour FSM/statistics RAM.

## Interface
- CAPACITY, 3, number of parking spaces (1..15)
- OPEN_CYC, 4, cycles gate stays open per grant (2..15)
- CNT_W, 4, occupancy / entry-count width
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- enter_req  in  1  level request from entry sensor, held until granted
- exit_req  in  1  level request from exit sensor, held until granted
- increaseTime  in  1  one-cycle hour-advance pulse (same pulse as hour FSM)
- hours  in  3  current hour from hour FSM
- endDay  in  1  day over; gate frozen while high
- enter_gnt  out  1  one-cycle grant to entry
- exit_gnt  out  1  one-cycle grant to exit
- gate_open  out  1  gate actuator
- occupancy  out  CNT_W  cars in lot
- full  out  1  occupancy == CAPACITY
- empty  out  1  occupancy == 0
- log_we  out  1  one-cycle write strobe for hourly entry log
- log_addr  out  3  hour being logged
- log_data  out  CNT_W  entries during that hour

## Operation
- States: IDLE, GRANT_IN, GRANT_OUT, OPEN, CLOSE.
- IDLE: eligible_in = enter_req & ~full & ~endDay; eligible_out = exit_req & ~empty & ~endDay. Single eligible -> its GRANT state. Both -> round-robin: winner is the side not served last; after reset, entry wins first.
- On the IDLE->GRANT_IN edge occupancy +1; IDLE->GRANT_OUT edge occupancy -1; last-served flag updated.
- GRANT_x (1 cycle): x_gnt=1, gate_open=1 -> OPEN.
- OPEN: gate_open=1 for OPEN_CYC-1 cycles (down-counter) -> CLOSE.
- CLOSE (1 cycle): gate_open=0, no grant -> IDLE.
- Requester must drop req the cycle after its grant; a req still high in IDLE is a new request.
- Ineligible requests (enter when full, exit when empty, any during endDay) stay pending, no grant, no error.
- full/empty combinational from occupancy register.
- Hour entry counter: +1 on each IDLE->GRANT_IN edge, saturates at 2^CNT_W-1.
- increaseTime pulse: log_we=1 next cycle, log_addr=hours sampled at pulse, log_data=counter value at pulse; counter reloads to 0, or 1 if an entry grant occurs on the same edge.
- endDay does not abort an in-progress gate cycle; it only blocks new grants.

## Timing
- Reset values: state IDLE, all grants 0, gate_open 0, occupancy 0, empty 1, full 0, log_we 0, log_addr 0, log_data 0, counter 0, last-served = exit.
- Request sampled at edge k -> grant and updated occupancy visible in cycle after k.
- gate_open high exactly OPEN_CYC cycles per grant; service period OPEN_CYC+1 cycles; earliest next grant OPEN_CYC+2 cycles after previous grant.
- log_we latency: 1 cycle after increaseTime; never two consecutive cycles.
- Reset mid-cycle: gate closes immediately, occupancy and log state cleared.

## Configuration
- GATE_STATS_EN defined: hourly entry counter and log outputs as above.
- Not defined: counter not built; log_we, log_addr, log_data tied to 0; increaseTime and hours unused; gate behaviour unchanged.

## Structure
- Package parking_pkg: gate_state_t enum, default CAPACITY, OPEN_CYC, CNT_W constants.
- Sub-module rr_arb2: two-input round-robin pick with last-served register, update enable.

## Test plan
- Reset, enter_req held -> enter_gnt one cycle after first sampling edge, gate_open 4 cycles, occupancy 1, empty 0.
- Three entries then enter_req held -> occupancy 3, full 1, no further enter_gnt until an exit completes; then entry granted.
- enter_req and exit_req both held with occupancy 1 -> grants alternate (entry, exit, entry), each separated by 6 cycles.
- exit_req with occupancy 0 -> no grant, gate_open stays 0.
- GATE_STATS_EN: 2 entries in hour 3, increaseTime -> log_we one cycle, log_addr 3, log_data 2; entry granted on pulse edge -> next hour counter starts at 1.
- endDay raised during OPEN -> current cycle completes; pending enter_req not granted until endDay falls; reset mid-OPEN -> gate_open 0 and occupancy 0 immediately.
